// File: rtl/rtc_time_decoder.sv
// rtl/rtc_time_decoder.sv - RTC seconds count to days/hours/minutes/seconds decoder
//
// Purpose:
//   A single restoring divider produces one quotient bit per clock. It runs three
//   chained stages: seconds/86400, then the day remainder /3600, then the hour
//   remainder /60. All stages share one subtractor. The divisor constant is selected
//   by the current state.
//
// Ports:
//   clk           in   1   system clock
//   rst_n         in   1   synchronous active-low reset
//   i_start       in   1   request pulse, sampled only while idle
//   i_seconds_in  in  32   seconds value, latched when i_start is accepted
//   o_busy        out  1   conversion in progress
//   o_done        out  1   one-cycle pulse when results are updated
//   o_days        out 16   i_seconds_in / 86400
//   o_hours       out  5   0..23
//   o_minutes     out  6   0..59
//   o_secs        out  6   0..59

module rtc_time_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_seconds_in,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_days,
    output logic [4:0]  o_hours,
    output logic [5:0]  o_minutes,
    output logic [5:0]  o_secs
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DIV_DAY  = 3'd1;
    localparam logic [2:0] S_DIV_HOUR = 3'd2;
    localparam logic [2:0] S_DIV_MIN  = 3'd3;
    localparam logic [2:0] S_FINISH   = 3'd4;

    logic [2:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_op;      // dividend, consumed MSB-first
    logic [16:0] r_rem;
    logic [14:0] r_quo;     // only the low 16 quotient bits of any stage can be non-zero
    logic [15:0] r_day_q;
    logic [4:0]  r_hour_q;
    logic [5:0]  r_min_q;
    logic [5:0]  r_sec_q;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_days;
    logic [4:0]  r_hours;
    logic [5:0]  r_minutes;
    logic [5:0]  r_secs;

    logic [17:0] w_divisor;
    logic [17:0] w_trial;
    logic [17:0] w_diff;
    logic        w_qbit;
    logic [16:0] w_rem_next;
    logic        w_unused;

    always_comb begin
        w_divisor = 18'd0;
        case (r_state)
            S_DIV_DAY:  w_divisor = 18'd86400;
            S_DIV_HOUR: w_divisor = 18'd3600;
            S_DIV_MIN:  w_divisor = 18'd60;
            default:    w_divisor = 18'd0;
        endcase
    end

    // Shared restoring step. The remainder stays below the divisor, so bit 17
    // of the trial and of the difference never survives into the next remainder.
    assign w_trial    = {r_rem, r_op[31]};
    assign w_diff     = w_trial - w_divisor;
    assign w_qbit     = (w_trial >= w_divisor);
    assign w_rem_next = w_qbit ? w_diff[16:0] : w_trial[16:0];
    assign w_unused   = w_trial[17] ^ w_diff[17];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_op      <= 32'd0;
            r_rem     <= 17'd0;
            r_quo     <= 15'd0;
            r_day_q   <= 16'd0;
            r_hour_q  <= 5'd0;
            r_min_q   <= 6'd0;
            r_sec_q   <= 6'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_days    <= 16'd0;
            r_hours   <= 5'd0;
            r_minutes <= 6'd0;
            r_secs    <= 6'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op    <= i_seconds_in;
                        r_rem   <= 17'd0;
                        r_quo   <= 15'd0;
                        r_cnt   <= 5'd31;
                        r_busy  <= 1'b1;
                        r_state <= S_DIV_DAY;
                    end
                end
                S_DIV_DAY, S_DIV_HOUR, S_DIV_MIN: begin
                    r_op  <= {r_op[30:0], 1'b0};
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[13:0], w_qbit};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        // Stage boundary: the remainder becomes the next dividend,
                        // left-aligned so its MSB feeds the next step.
                        r_rem <= 17'd0;
                        r_quo <= 15'd0;
                        if (r_state == S_DIV_DAY) begin
                            r_day_q <= {r_quo, w_qbit};
                            r_op    <= {w_rem_next, 15'd0};
                            r_cnt   <= 5'd16;
                            r_state <= S_DIV_HOUR;
                        end else if (r_state == S_DIV_HOUR) begin
                            r_hour_q <= {r_quo[3:0], w_qbit};
                            r_op     <= {w_rem_next[11:0], 20'd0};
                            r_cnt    <= 5'd11;
                            r_state  <= S_DIV_MIN;
                        end else begin
                            r_min_q <= {r_quo[4:0], w_qbit};
                            r_sec_q <= w_rem_next[5:0];
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_days    <= r_day_q;
                    r_hours   <= r_hour_q;
                    r_minutes <= r_min_q;
                    r_secs    <= r_sec_q;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_days    = r_days;
    assign o_hours   = r_hours;
    assign o_minutes = r_minutes;
    assign o_secs    = r_secs;

endmodule
